i2c_master_regs: RTL and testbench

I2C_MASTER_REGS -- requirements
Module: i2c_master_regs

---
 rtl/i2c_master_regs.sv | 172 +++++++++++++++++
 tb/tb_i2c_master_regs.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_regs.sv
// Register file for an I2C master: prescaler, control, transmit, command and
// status registers, plus the interrupt request. Status bits are fed by the
// byte/bit controller core. Readback is combinational from Addr.
module i2c_master_regs #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 3
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [AWIDTH-1:0] Addr,
    input  logic [DWIDTH-1:0] DataIn,
    output logic [DWIDTH-1:0] DataOut,
    input  logic              Wr,
    output logic              Int,
    output logic              Start,
    output logic              Stop,
    output logic              Read,
    output logic              Write,
    output logic              Tx_ack,
    output logic [7:0]        Tx_data,
    output logic [7:0]        Prescale,
    output logic              I2C_en,
    input  logic              Rx_ack,
    input  logic [7:0]        Rx_data,
    input  logic              I2C_busy,
    input  logic              I2C_done,
    input  logic              I2C_al
);

    // Register addresses
    localparam logic [AWIDTH-1:0] ADDR_PRER = AWIDTH'(0);
    localparam logic [AWIDTH-1:0] ADDR_CTR  = AWIDTH'(1);
    localparam logic [AWIDTH-1:0] ADDR_TXR  = AWIDTH'(2);
    localparam logic [AWIDTH-1:0] ADDR_CR   = AWIDTH'(3);
    localparam logic [AWIDTH-1:0] ADDR_RXR  = AWIDTH'(4);
    localparam logic [AWIDTH-1:0] ADDR_SR   = AWIDTH'(5);

    // CR bit positions
    localparam int CR_STA    = 7;
    localparam int CR_STO    = 6;
    localparam int CR_RD     = 5;
    localparam int CR_WR     = 4;
    localparam int CR_ACK    = 3;
    localparam int CR_AL_ACK = 2;
    localparam int CR_IACK   = 0;

    logic [7:0] data_in8;
    logic [7:0] rd_data8;

    logic [7:0] prer_reg, prer_next;
    logic [7:0] ctr_reg,  ctr_next;
    logic [7:0] txr_reg,  txr_next;
    logic [7:0] cr_reg,   cr_next;
    logic       rxack_reg;
    logic       busy_reg;
    logic       al_reg,   al_next;
    logic       if_reg,   if_next;
    logic       int_reg;

    logic       wr_prer, wr_ctr, wr_txr, wr_cr;
    logic       xfer_end;
    logic       tip;
    logic [7:0] sr_value;

    // The register map is 8 bits wide; adapt it to the bus width.
    generate
        if (DWIDTH == 8) begin : g_bus_eq
            assign data_in8 = DataIn;
            assign DataOut  = rd_data8;
        end else if (DWIDTH > 8) begin : g_bus_wide
            assign data_in8 = DataIn[7:0];
            assign DataOut  = {{(DWIDTH-8){1'b0}}, rd_data8};
        end else begin : g_bus_narrow
            assign data_in8 = {{(8-DWIDTH){1'b0}}, DataIn};
            assign DataOut  = rd_data8[DWIDTH-1:0];
        end
    endgenerate

    assign wr_prer  = Wr && (Addr == ADDR_PRER);
    assign wr_ctr   = Wr && (Addr == ADDR_CTR);
    assign wr_txr   = Wr && (Addr == ADDR_TXR);
    assign wr_cr    = Wr && (Addr == ADDR_CR);
    assign xfer_end = I2C_done | I2C_al;

    assign tip      = cr_reg[CR_RD] | cr_reg[CR_WR];
    assign sr_value = {rxack_reg, busy_reg, al_reg, 3'b000, tip, if_reg};

    // Next-state for the writable registers and the sticky status flags
    always_comb begin
        prer_next = prer_reg;
        ctr_next  = ctr_reg;
        txr_next  = txr_reg;
        cr_next   = cr_reg;
        al_next   = al_reg;
        if_next   = if_reg;

        if (wr_prer) prer_next = data_in8;
        if (wr_ctr)  ctr_next  = data_in8;
        if (wr_txr)  txr_next  = data_in8;

        // IACK and AL_ACK are one-cycle strobes; bit 1 is never stored.
        cr_next[CR_IACK]   = 1'b0;
        cr_next[CR_AL_ACK] = 1'b0;
        if (wr_cr) begin
            cr_next = {data_in8[7:2], 1'b0, data_in8[0]};
        end
        // End of transfer retires the command, overriding a concurrent write.
        if (xfer_end) begin
            cr_next[CR_STA]  = 1'b0;
            cr_next[CR_STO]  = 1'b0;
            cr_next[CR_RD]   = 1'b0;
            cr_next[CR_WR]   = 1'b0;
            cr_next[CR_IACK] = 1'b0;
        end

        // Acknowledge clears a flag, but a new event in the same cycle wins.
        if (wr_cr && data_in8[CR_IACK])   if_next = 1'b0;
        if (xfer_end)                     if_next = 1'b1;
        if (wr_cr && data_in8[CR_AL_ACK]) al_next = 1'b0;
        if (I2C_al)                       al_next = 1'b1;
    end

    // State registers; reset clears any pending command or flag
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            prer_reg  <= 8'hFF;
            ctr_reg   <= 8'h00;
            txr_reg   <= 8'h00;
            cr_reg    <= 8'h00;
            rxack_reg <= 1'b0;
            busy_reg  <= 1'b0;
            al_reg    <= 1'b0;
            if_reg    <= 1'b0;
            int_reg   <= 1'b0;
        end else begin
            prer_reg  <= prer_next;
            ctr_reg   <= ctr_next;
            txr_reg   <= txr_next;
            cr_reg    <= cr_next;
            rxack_reg <= Rx_ack;
            busy_reg  <= I2C_busy;
            al_reg    <= al_next;
            if_reg    <= if_next;
            int_reg   <= if_reg & ctr_reg[6];
        end
    end

    // Combinational readback mux
    always_comb begin
        rd_data8 = 8'h00;
        case (Addr)
            ADDR_PRER: rd_data8 = prer_reg;
            ADDR_CTR:  rd_data8 = ctr_reg;
            ADDR_TXR:  rd_data8 = txr_reg;
            ADDR_CR:   rd_data8 = cr_reg;
            ADDR_RXR:  rd_data8 = Rx_data;
            ADDR_SR:   rd_data8 = sr_value;
            default:   rd_data8 = 8'h00;
        endcase
    end

    assign Start    = cr_reg[CR_STA];
    assign Stop     = cr_reg[CR_STO];
    assign Read     = cr_reg[CR_RD];
    assign Write    = cr_reg[CR_WR];
    assign Tx_ack   = cr_reg[CR_ACK];
    assign Tx_data  = txr_reg;
    assign Prescale = prer_reg;
    assign I2C_en   = ctr_reg[7];
    assign Int      = int_reg;

endmodule

// File: tb/tb_i2c_master_regs.sv
// Directed bench for i2c_master_regs: table of register write/readback
// vectors, then hand-written sequences for command clearing, status flags,
// interrupt timing and asynchronous reset.
module tb_i2c_master_regs;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic [2:0] Addr;
    logic [7:0] DataIn;
    logic [7:0] DataOut;
    logic       Wr;
    logic       Int;
    logic       Start, Stop, Read, Write, Tx_ack;
    logic [7:0] Tx_data;
    logic [7:0] Prescale;
    logic       I2C_en;
    logic       Rx_ack;
    logic [7:0] Rx_data;
    logic       I2C_busy, I2C_done, I2C_al;

    int n_total = 0;
    int n_pass  = 0;

    i2c_master_regs #(.DWIDTH(8), .AWIDTH(3)) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Addr     (Addr),
        .DataIn   (DataIn),
        .DataOut  (DataOut),
        .Wr       (Wr),
        .Int      (Int),
        .Start    (Start),
        .Stop     (Stop),
        .Read     (Read),
        .Write    (Write),
        .Tx_ack   (Tx_ack),
        .Tx_data  (Tx_data),
        .Prescale (Prescale),
        .I2C_en   (I2C_en),
        .Rx_ack   (Rx_ack),
        .Rx_data  (Rx_data),
        .I2C_busy (I2C_busy),
        .I2C_done (I2C_done),
        .I2C_al   (I2C_al)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [2:0] waddr;
        logic [7:0] wdata;
        logic [2:0] raddr;
        logic [7:0] rexp;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        else begin
            n_pass++;
            $display("ok   %s: 0x%02h", name, act);
        end
    endtask

    // Bus write: drive on a falling edge, sampled on the next rising edge.
    task automatic reg_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge Clk);
        Addr = a; DataIn = d; Wr = 1'b1;
        @(negedge Clk);
        Wr = 1'b0;
    endtask

    task automatic reg_read(input logic [2:0] a, output logic [7:0] d);
        Addr = a;
        #1;
        d = DataOut;
    endtask

    task automatic pulse(input logic done, input logic al);
        @(negedge Clk);
        I2C_done = done; I2C_al = al;
        @(negedge Clk);
        I2C_done = 1'b0; I2C_al = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;

        vecs[0]  = '{3'd2, 8'hAA, 3'd2, 8'hAA};
        vecs[1]  = '{3'd2, 8'h55, 3'd2, 8'h55};
        vecs[2]  = '{3'd2, 8'h00, 3'd2, 8'h00};
        vecs[3]  = '{3'd1, 8'hAA, 3'd1, 8'hAA};
        vecs[4]  = '{3'd1, 8'h55, 3'd1, 8'h55};
        vecs[5]  = '{3'd1, 8'hC3, 3'd1, 8'hC3};
        vecs[6]  = '{3'd1, 8'h00, 3'd1, 8'h00};
        vecs[7]  = '{3'd0, 8'hAA, 3'd0, 8'hAA};
        vecs[8]  = '{3'd0, 8'h55, 3'd0, 8'h55};
        vecs[9]  = '{3'd0, 8'h00, 3'd0, 8'h00};
        vecs[10] = '{3'd4, 8'hFF, 3'd4, 8'h3C};
        vecs[11] = '{3'd5, 8'hFF, 3'd5, 8'h00};
        vecs[12] = '{3'd6, 8'hFF, 3'd6, 8'h00};
        vecs[13] = '{3'd7, 8'hFF, 3'd7, 8'h00};
        vecs[14] = '{3'd3, 8'h02, 3'd3, 8'h00};
        vecs[15] = '{3'd4, 8'h11, 3'd0, 8'h00};

        Rst_n = 1'b0; Addr = 3'd0; DataIn = 8'h00; Wr = 1'b0;
        Rx_ack = 1'b0; Rx_data = 8'h3C; I2C_busy = 1'b0;
        I2C_done = 1'b0; I2C_al = 1'b0;

        // Reset state, sampled while reset is held
        @(negedge Clk);
        reg_read(3'd0, rd); check("rst PRER", rd, 8'hFF);
        reg_read(3'd1, rd); check("rst CTR", rd, 8'h00);
        reg_read(3'd2, rd); check("rst TXR", rd, 8'h00);
        reg_read(3'd3, rd); check("rst CR", rd, 8'h00);
        reg_read(3'd5, rd); check("rst SR", rd, 8'h00);
        check("rst Prescale", Prescale, 8'hFF);
        check("rst Tx_data", Tx_data, 8'h00);
        check("rst outs", {1'b0, Int, Start, Stop, Read, Write, Tx_ack, I2C_en}, 8'h00);
        @(negedge Clk);
        Rst_n = 1'b1;

        // Table-driven write/readback
        for (int i = 0; i < 16; i++) begin
            reg_write(vecs[i].waddr, vecs[i].wdata);
            reg_read(vecs[i].raddr, rd);
            check($sformatf("vec%0d rd a%0d", i, vecs[i].raddr), rd, vecs[i].rexp);
            if (vecs[i].waddr == 3'd0) check($sformatf("vec%0d Prescale", i), Prescale, vecs[i].wdata);
            if (vecs[i].waddr == 3'd1) check($sformatf("vec%0d I2C_en", i), {7'd0, I2C_en}, {7'd0, vecs[i].wdata[7]});
            if (vecs[i].waddr == 3'd2) check($sformatf("vec%0d Tx_data", i), Tx_data, vecs[i].wdata);
        end

        // RXR/SR inputs: busy is registered
        I2C_busy = 1'b1;
        @(negedge Clk);
        reg_read(3'd4, rd); check("RXR data", rd, 8'h3C);
        reg_read(3'd5, rd); check("SR busy", rd, 8'h40);
        I2C_busy = 1'b0;
        @(negedge Clk);

        // Command autoclear on done
        reg_write(3'd3, 8'h90);
        check("cmd start/write", {6'd0, Start, Write}, 8'h03);
        reg_read(3'd5, rd); check("SR TIP set", rd, 8'h02);
        Rx_ack = 1'b1;
        pulse(1'b1, 1'b0);
        reg_read(3'd3, rd); check("CR cleared by done", rd, 8'h00);
        reg_read(3'd5, rd); check("SR after done", rd, 8'h81);
        Rx_ack = 1'b0;
        reg_write(3'd3, 8'h01);
        reg_read(3'd3, rd); check("CR IACK visible", rd, 8'h01);
        reg_read(3'd5, rd); check("SR IF cleared", rd, 8'h00);
        @(negedge Clk);
        reg_read(3'd3, rd); check("CR IACK autoclear", rd, 8'h00);

        // Arbitration lost
        reg_write(3'd3, 8'h20);
        check("cmd read", {7'd0, Read}, 8'h01);
        pulse(1'b0, 1'b1);
        reg_read(3'd3, rd); check("CR cleared by al", rd, 8'h00);
        reg_read(3'd5, rd); check("SR after al", rd, 8'h21);
        reg_write(3'd3, 8'h04);
        reg_read(3'd5, rd); check("SR AL acked", rd, 8'h01);
        reg_read(3'd3, rd); check("CR AL_ACK visible", rd, 8'h04);
        @(negedge Clk);
        reg_read(3'd3, rd); check("CR AL_ACK autoclear", rd, 8'h00);
        reg_write(3'd3, 8'h01);
        reg_read(3'd5, rd); check("SR idle", rd, 8'h00);

        // Interrupt with IEN=1: Int lags IF by one cycle
        reg_write(3'd1, 8'hC0);
        check("I2C_en", {7'd0, I2C_en}, 8'h01);
        pulse(1'b1, 1'b0);
        reg_read(3'd5, rd); check("IF set", rd, 8'h01);
        check("Int lag", {7'd0, Int}, 8'h00);
        @(negedge Clk);
        check("Int raised", {7'd0, Int}, 8'h01);
        reg_write(3'd3, 8'h01);
        reg_read(3'd5, rd); check("IF cleared by IACK", rd, 8'h00);
        check("Int still high", {7'd0, Int}, 8'h01);
        @(negedge Clk);
        check("Int dropped", {7'd0, Int}, 8'h00);

        // Interrupt with IEN=0
        reg_write(3'd1, 8'h80);
        pulse(1'b1, 1'b0);
        repeat (3) @(negedge Clk);
        check("no Int on done", {7'd0, Int}, 8'h00);
        pulse(1'b0, 1'b1);
        repeat (3) @(negedge Clk);
        check("no Int on al", {7'd0, Int}, 8'h00);
        reg_read(3'd5, rd); check("SR IF+AL", rd, 8'h21);
        reg_write(3'd3, 8'h05);
        reg_read(3'd5, rd); check("SR both acked", rd, 8'h00);

        // Done concurrent with a CR write: clear and IF set win, ACK kept
        @(negedge Clk);
        Addr = 3'd3; DataIn = 8'h99; Wr = 1'b1; I2C_done = 1'b1;
        @(negedge Clk);
        Wr = 1'b0; I2C_done = 1'b0;
        reg_read(3'd3, rd); check("CR clear priority", rd, 8'h08);
        check("Tx_ack kept", {7'd0, Tx_ack}, 8'h01);
        reg_read(3'd5, rd); check("IF set priority", rd, 8'h01);

        // al concurrent with AL_ACK write: AL set wins
        @(negedge Clk);
        Addr = 3'd3; DataIn = 8'h04; Wr = 1'b1; I2C_al = 1'b1;
        @(negedge Clk);
        Wr = 1'b0; I2C_al = 1'b0;
        reg_read(3'd5, rd); check("AL set priority", rd, 8'h21);
        reg_write(3'd3, 8'h05);
        reg_read(3'd5, rd); check("SR cleared again", rd, 8'h00);

        // Reset mid-operation
        reg_write(3'd1, 8'hC0);
        reg_write(3'd2, 8'h5A);
        reg_write(3'd0, 8'h12);
        pulse(1'b1, 1'b0);
        reg_write(3'd3, 8'h98);
        I2C_busy = 1'b1;
        @(negedge Clk);
        check("pre-rst Int", {7'd0, Int}, 8'h01);
        #2 Rst_n = 1'b0;
        #1;
        check("arst outs", {1'b0, Int, Start, Stop, Read, Write, Tx_ack, I2C_en}, 8'h00);
        reg_read(3'd3, rd); check("arst CR", rd, 8'h00);
        reg_read(3'd5, rd); check("arst SR", rd, 8'h00);
        reg_read(3'd0, rd); check("arst PRER", rd, 8'hFF);
        reg_read(3'd1, rd); check("arst CTR", rd, 8'h00);
        reg_read(3'd2, rd); check("arst TXR", rd, 8'h00);
        check("arst Prescale", Prescale, 8'hFF);
        check("arst Tx_data", Tx_data, 8'h00);
        @(negedge Clk);
        Rst_n = 1'b1;
        I2C_busy = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
